loong_arbiter: RTL and testbench

LOONG_ARBITER -- requirements
Module: loong_arbiter

---
 rtl/loong_arbiter_if.sv | 34 +++
 rtl/loong_arbiter.sv | 154 +++++++++++++++
 tb/tb_loong_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/loong_arbiter_if.sv
// Bus bundle between two requesters, the LOONG encryption core and the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface loong_arbiter_if;
  logic        req0;
  logic        req1;
  logic [63:0] pt0;
  logic [63:0] pt1;
  logic [63:0] key0;
  logic [63:0] key1;
  logic        ack0;
  logic        ack1;
  logic        core_start;
  logic [63:0] core_pt;
  logic [63:0] core_key;
  logic        core_done;
  logic [63:0] core_ct;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_id;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req0, req1, pt0, pt1, key0, key1, core_done, core_ct,
    output ack0, ack1, core_start, core_pt, core_key,
    output rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport master (
    output req0, req1, pt0, pt1, key0, key1, core_done, core_ct,
    input  ack0, ack1, core_start, core_pt, core_key,
    input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/loong_arbiter.sv
// Two-requester round-robin front end for a single LOONG encryption core:
// one job in flight, operand capture, core start pulse, timeout and response.
module loong_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic            clk,
  input  logic            reset,
  loong_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_r;
  state_t      state_s;
  logic        last_grant_r;
  logic        owner_r;
  logic [15:0] tmo_cnt_r;
  logic [15:0] tmo_cnt_s;
  logic [15:0] tmo_inc_s;
  logic        grant_s;
  logic        grant_id_s;
  logic        done_s;
  logic        timeout_s;

  logic        core_start_r;
  logic [63:0] core_pt_r;
  logic [63:0] core_key_r;
  logic        rsp_valid_r;
  logic [63:0] rsp_data_r;
  logic        rsp_id_r;
  logic        rsp_err_r;
  logic        busy_r;

  // Next-state, arbitration and timeout decisions.
  always_comb begin
    state_s    = state_r;
    grant_s    = 1'b0;
    grant_id_s = 1'b0;
    done_s     = 1'b0;
    timeout_s  = 1'b0;
    tmo_inc_s  = tmo_cnt_r + 16'd1;
    tmo_cnt_s  = tmo_cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_s = 1'b1;
          // On contention the requester that did not win last time goes first.
          if (bus.req0 && bus.req1) begin
            grant_id_s = ~last_grant_r;
          end else begin
            grant_id_s = bus.req1;
          end
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        tmo_cnt_s = 16'd0;
        state_s   = RUN;
      end
      RUN: begin
        tmo_cnt_s = tmo_inc_s;
        // A completion on the timeout cycle still counts as success.
        if (bus.core_done) begin
          done_s  = 1'b1;
          state_s = RESP;
        end else if (tmo_inc_s == TMO_LIMIT) begin
          timeout_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = RUN;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, timeout counter, response and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      tmo_cnt_r    <= 16'd0;
      core_start_r <= 1'b0;
      core_pt_r    <= 64'd0;
      core_key_r   <= 64'd0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 64'd0;
      rsp_id_r     <= 1'b0;
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      tmo_cnt_r    <= tmo_cnt_s;
      core_start_r <= (state_s == LOAD);
      rsp_valid_r  <= (state_s == RESP);
      busy_r       <= (state_s != IDLE);
      if (grant_s) begin
        last_grant_r <= grant_id_s;
        owner_r      <= grant_id_s;
        core_pt_r    <= grant_id_s ? bus.pt1  : bus.pt0;
        core_key_r   <= grant_id_s ? bus.key1 : bus.key0;
      end else begin
        last_grant_r <= last_grant_r;
        owner_r      <= owner_r;
      end
      if (done_s) begin
        rsp_data_r <= bus.core_ct;
        rsp_id_r   <= owner_r;
        rsp_err_r  <= 1'b0;
      end else if (timeout_s) begin
        rsp_data_r <= 64'd0;
        rsp_id_r   <= owner_r;
        rsp_err_r  <= 1'b1;
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  // The grant is visible in the IDLE cycle that makes it, so ack cannot coincide with busy.
  assign bus.ack0       = grant_s & ~grant_id_s & ~reset;
  assign bus.ack1       = grant_s &  grant_id_s & ~reset;
  assign bus.core_start = core_start_r;
  assign bus.core_pt    = core_pt_r;
  assign bus.core_key   = core_key_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_loong_arbiter.sv
// Directed bench for loong_arbiter (TIMEOUT_CYCLES=8): single job, contention order,
// timeout, done on the timeout cycle, reset mid-job and operand stability.
module tb_loong_arbiter;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   ack0_cnt;
  int   ack1_cnt;
  int   rsp_cnt;
  int   dual_ack;

  loong_arbiter_if bus_if ();

  loong_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters observed away from the active edge.
  always @(negedge clk) begin
    if (bus_if.ack0 === 1'b1) ack0_cnt++;
    if (bus_if.ack1 === 1'b1) ack1_cnt++;
    if (bus_if.rsp_valid === 1'b1) rsp_cnt++;
    if (bus_if.ack0 === 1'b1 && bus_if.ack1 === 1'b1) dual_ack++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [63:0] ct_tab [3];
  logic        id_tab [3];
  logic [63:0] p0;
  logic [63:0] p1;
  logic [63:0] ka;
  logic [63:0] pa;

  initial begin
    n_cmp = 0; n_err = 0; ack0_cnt = 0; ack1_cnt = 0; rsp_cnt = 0; dual_ack = 0;
    reset = 1'b1;
    bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
    bus_if.pt0 = 64'd0; bus_if.pt1 = 64'd0; bus_if.key0 = 64'd0; bus_if.key1 = 64'd0;
    bus_if.core_done = 1'b0; bus_if.core_ct = 64'd0;
    ct_tab[0] = 64'h1111_2222_3333_4444; id_tab[0] = 1'b0;
    ct_tab[1] = 64'h5555_6666_7777_8888; id_tab[1] = 1'b1;
    ct_tab[2] = 64'h9999_AAAA_BBBB_CCCC; id_tab[2] = 1'b0;
    p0 = 64'hA0A0_A0A0_0000_0001;
    p1 = 64'hB1B1_B1B1_0000_0002;
    pa = 64'h0F0F_1234_5678_9ABC;
    ka = 64'hFFFF_0000_AAAA_5555;

    // Reset state.
    tick(); tick(); smp();
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_ack0", 64'(bus_if.ack0), 64'd0);
    chk("rst_start", 64'(bus_if.core_start), 64'd0);
    chk("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    chk("rst_core_pt", bus_if.core_pt, 64'd0);
    chk("rst_rsp_data", bus_if.rsp_data, 64'd0);

    // Single job from requester 0, done five cycles after start.
    tick(); reset = 1'b0; smp();
    tick(); bus_if.req0 = 1'b1; bus_if.pt0 = 64'h0123_4567_89AB_CDEF; bus_if.key0 = 64'd0; smp();
    chk("t1_ack0", 64'(bus_if.ack0), 64'd1);
    chk("t1_ack1", 64'(bus_if.ack1), 64'd0);
    chk("t1_busy_at_ack", 64'(bus_if.busy), 64'd0);
    tick(); bus_if.req0 = 1'b0; smp();
    chk("t1_start", 64'(bus_if.core_start), 64'd1);
    chk("t1_busy", 64'(bus_if.busy), 64'd1);
    chk("t1_core_pt", bus_if.core_pt, 64'h0123_4567_89AB_CDEF);
    chk("t1_core_key", bus_if.core_key, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); smp();
      chk("t1_run_no_rsp", 64'(bus_if.rsp_valid), 64'd0);
      chk("t1_run_no_start", 64'(bus_if.core_start), 64'd0);
    end
    tick(); bus_if.core_done = 1'b1; bus_if.core_ct = 64'hDEAD_BEEF_CAFE_F00D; smp();
    chk("t1_done_cycle", 64'(bus_if.rsp_valid), 64'd0);
    tick(); bus_if.core_done = 1'b0; smp();
    chk("t1_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
    chk("t1_rsp_id", 64'(bus_if.rsp_id), 64'd0);
    chk("t1_rsp_err", 64'(bus_if.rsp_err), 64'd0);
    chk("t1_rsp_data", bus_if.rsp_data, 64'hDEAD_BEEF_CAFE_F00D);
    tick(); smp();
    chk("t1_rsp_pulse", 64'(bus_if.rsp_valid), 64'd0);
    chk("t1_idle", 64'(bus_if.busy), 64'd0);
    chk("t1_rsp_hold", bus_if.rsp_data, 64'hDEAD_BEEF_CAFE_F00D);

    // Contention straight after reset, minimum-latency back-to-back jobs.
    tick(); reset = 1'b1; smp();
    tick(); reset = 1'b0;
    bus_if.req0 = 1'b1; bus_if.req1 = 1'b1; bus_if.pt0 = p0; bus_if.pt1 = p1; smp();
    for (int k = 0; k < 3; k++) begin
      chk("t2_ack0", 64'(bus_if.ack0), 64'(id_tab[k] == 1'b0));
      chk("t2_ack1", 64'(bus_if.ack1), 64'(id_tab[k] == 1'b1));
      tick(); smp();
      chk("t2_start", 64'(bus_if.core_start), 64'd1);
      chk("t2_core_pt", bus_if.core_pt, id_tab[k] ? p1 : p0);
      tick(); bus_if.core_done = 1'b1; bus_if.core_ct = ct_tab[k]; smp();
      tick(); bus_if.core_done = 1'b0;
      if (k == 2) begin
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
      end
      smp();
      chk("t2_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
      chk("t2_rsp_id", 64'(bus_if.rsp_id), 64'(id_tab[k]));
      chk("t2_rsp_data", bus_if.rsp_data, ct_tab[k]);
      tick(); smp();
    end
    chk("t2_idle", 64'(bus_if.busy), 64'd0);
    chk("t2_no_ack", 64'({bus_if.ack1, bus_if.ack0}), 64'd0);

    // Timeout: core never answers.
    tick(); bus_if.req1 = 1'b1; bus_if.pt1 = 64'h3333_0000_3333_0000; smp();
    chk("t3_ack1", 64'(bus_if.ack1), 64'd1);
    tick(); bus_if.req1 = 1'b0; smp();
    chk("t3_start", 64'(bus_if.core_start), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick(); smp();
      chk("t3_run_no_rsp", 64'(bus_if.rsp_valid), 64'd0);
      chk("t3_run_busy", 64'(bus_if.busy), 64'd1);
    end
    tick(); smp();
    chk("t3_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
    chk("t3_rsp_err", 64'(bus_if.rsp_err), 64'd1);
    chk("t3_rsp_data", bus_if.rsp_data, 64'd0);
    chk("t3_rsp_id", 64'(bus_if.rsp_id), 64'd1);
    tick(); smp();
    chk("t3_idle", 64'(bus_if.busy), 64'd0);

    // core_done on the eighth RUN cycle wins over the timeout.
    tick(); bus_if.req0 = 1'b1; bus_if.pt0 = 64'h4444_4444_0000_0004; smp();
    chk("t4_ack0", 64'(bus_if.ack0), 64'd1);
    tick(); bus_if.req0 = 1'b0; smp();
    chk("t4_start", 64'(bus_if.core_start), 64'd1);
    for (int i = 0; i < 7; i++) begin
      tick(); smp();
      chk("t4_run_no_rsp", 64'(bus_if.rsp_valid), 64'd0);
    end
    tick(); bus_if.core_done = 1'b1; bus_if.core_ct = 64'h0BAD_F00D_1234_5678; smp();
    chk("t4_done_cycle", 64'(bus_if.rsp_valid), 64'd0);
    tick(); bus_if.core_done = 1'b0; smp();
    chk("t4_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
    chk("t4_rsp_err", 64'(bus_if.rsp_err), 64'd0);
    chk("t4_rsp_data", bus_if.rsp_data, 64'h0BAD_F00D_1234_5678);
    chk("t4_rsp_id", 64'(bus_if.rsp_id), 64'd0);
    tick(); smp();
    chk("t4_idle", 64'(bus_if.busy), 64'd0);

    // Reset during RUN, then a late core_done, then a normal job.
    tick(); bus_if.req1 = 1'b1; bus_if.pt1 = 64'h5555_0000_0000_0005; smp();
    chk("t5_ack1", 64'(bus_if.ack1), 64'd1);
    tick(); bus_if.req1 = 1'b0; smp();
    tick(); smp();
    tick(); reset = 1'b1; smp();
    tick(); reset = 1'b0; bus_if.core_done = 1'b1; bus_if.core_ct = 64'hFFFF_FFFF_FFFF_FFFF; smp();
    chk("t5_busy_after_rst", 64'(bus_if.busy), 64'd0);
    chk("t5_no_rsp", 64'(bus_if.rsp_valid), 64'd0);
    chk("t5_core_pt_clr", bus_if.core_pt, 64'd0);
    chk("t5_rsp_data_clr", bus_if.rsp_data, 64'd0);
    tick(); bus_if.core_done = 1'b0; smp();
    chk("t5_late_done_ignored", 64'(bus_if.rsp_valid), 64'd0);
    chk("t5_still_idle", 64'(bus_if.busy), 64'd0);
    tick(); bus_if.req1 = 1'b1; bus_if.pt1 = 64'h6666_0000_0000_0006; smp();
    chk("t5_ack1_again", 64'(bus_if.ack1), 64'd1);
    tick(); bus_if.req1 = 1'b0; smp();
    chk("t5_start", 64'(bus_if.core_start), 64'd1);
    chk("t5_core_pt", bus_if.core_pt, 64'h6666_0000_0000_0006);
    tick(); bus_if.core_done = 1'b1; bus_if.core_ct = 64'h0600_0600_0600_0600; smp();
    tick(); bus_if.core_done = 1'b0; smp();
    chk("t5_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
    chk("t5_rsp_data", bus_if.rsp_data, 64'h0600_0600_0600_0600);
    chk("t5_rsp_id", 64'(bus_if.rsp_id), 64'd1);
    tick(); smp();

    // Operand changes while busy are ignored; the core model encrypts what it was given.
    tick(); bus_if.req1 = 1'b1; bus_if.pt1 = pa; bus_if.key1 = ka; smp();
    chk("t6_ack1", 64'(bus_if.ack1), 64'd1);
    tick(); bus_if.req1 = 1'b0; smp();
    chk("t6_start", 64'(bus_if.core_start), 64'd1);
    tick(); bus_if.pt1 = 64'h1234_1234_1234_1234; bus_if.key1 = 64'h0; bus_if.req0 = 1'b1; smp();
    chk("t6_no_ack_busy", 64'(bus_if.ack0), 64'd0);
    chk("t6_core_pt", bus_if.core_pt, pa);
    chk("t6_core_key", bus_if.core_key, ka);
    tick(); bus_if.core_done = 1'b1; bus_if.core_ct = bus_if.core_pt ^ bus_if.core_key; smp();
    tick(); bus_if.core_done = 1'b0; bus_if.req0 = 1'b0; smp();
    chk("t6_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
    chk("t6_rsp_data", bus_if.rsp_data, pa ^ ka);
    chk("t6_rsp_id", 64'(bus_if.rsp_id), 64'd1);
    tick(); smp();
    chk("t6_idle", 64'(bus_if.busy), 64'd0);
    chk("t6_no_ack", 64'(bus_if.ack0), 64'd0);

    // Pulse totals over the whole run.
    #1;
    chk("tot_ack0", 64'(ack0_cnt), 64'd4);
    chk("tot_ack1", 64'(ack1_cnt), 64'd5);
    chk("tot_rsp", 64'(rsp_cnt), 64'd8);
    chk("tot_dual_ack", 64'(dual_ack), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
